// File: rtl/max7219_receiver_if.sv
// SPI pin bundle of one MAX7219 link: LOAD/CS strobe, serial clock, data in and chain data out.
interface max7219_receiver_if;
   logic SPI_Stb;
   logic SPI_Clk;
   logic SPI_Din;
   logic SPI_Dout;

   modport master (output SPI_Stb, output SPI_Clk, output SPI_Din, input  SPI_Dout);
   modport slave  (input  SPI_Stb, input  SPI_Clk, input  SPI_Din, output SPI_Dout);
endinterface

// File: rtl/max7219_receiver.sv
// MAX7219 receiver: oversampled 3-wire SPI, register file, masked 8x8 image and daisy-chain output.
// Optional display-test register 0xF is built only when MAX7219_RX_DISPLAY_TEST_EN is defined.
module max7219_receiver #(
   parameter int SYNC_STAGES   = 2,
   parameter int ERR_CNT_WIDTH = 8
) (
   input  logic                     i_Clk,
   input  logic                     i_Rst_n,
   max7219_receiver_if.slave        spi,
   output logic [7:0][7:0]          o_FrameBuf,
   output logic [3:0]               o_Intensity,
   output logic [2:0]               o_Scan_Limit,
   output logic [7:0]               o_Decode,
   output logic                     o_Shutdown,
   output logic                     o_Test,
   output logic                     o_Wr_Stb,
   output logic [3:0]               o_Wr_Addr,
   output logic [7:0]               o_Wr_Data,
   output logic                     o_Frame_Err,
   output logic [ERR_CNT_WIDTH-1:0] o_Err_Count
);

   logic [SYNC_STAGES-1:0]   stb_sync_r;
   logic [SYNC_STAGES-1:0]   clk_sync_r;
   logic [SYNC_STAGES-1:0]   din_sync_r;
   logic                     stb_d_r;
   logic                     clk_d_r;
   logic                     stb_q_s;
   logic                     clk_q_s;
   logic                     din_q_s;
   logic                     stb_rise_s;
   logic                     stb_fall_s;
   logic                     clk_rise_s;
   logic                     clk_fall_s;
   logic                     shift_en_s;
   logic [15:0]              sr_r;
   logic [15:0]              sr_nxt_s;
   logic [4:0]               cnt_r;
   logic [4:0]               cnt_nxt_s;
   logic                     dout_r;
   logic                     word_ok_s;
   logic                     frame_bad_s;
   logic [3:0]               wr_addr_s;
   logic [7:0]               wr_data_s;
   logic [7:0][7:0]          digit_r;
   logic [3:0]               intensity_r;
   logic [2:0]               scan_r;
   logic [7:0]               decode_r;
   logic                     shutdown_r;
   logic                     test_s;
   logic                     wr_stb_r;
   logic [3:0]               wr_addr_r;
   logic [7:0]               wr_data_r;
   logic                     frame_err_r;
   logic [ERR_CNT_WIDTH-1:0] err_cnt_r;
   logic [7:0][7:0]          frame_nxt_s;
   logic [7:0][7:0]          frame_r;

`ifdef MAX7219_RX_DISPLAY_TEST_EN
   logic                     test_r;
   assign test_s = test_r;
`else
   assign test_s = 1'b0;
`endif

   // Pin synchronizers, preset to the idle bus so reset release creates no edge.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         stb_sync_r <= '1;
         clk_sync_r <= '0;
         din_sync_r <= '0;
         stb_d_r    <= 1'b1;
         clk_d_r    <= 1'b0;
      end else begin
         stb_sync_r <= {stb_sync_r[SYNC_STAGES-2:0], spi.SPI_Stb};
         clk_sync_r <= {clk_sync_r[SYNC_STAGES-2:0], spi.SPI_Clk};
         din_sync_r <= {din_sync_r[SYNC_STAGES-2:0], spi.SPI_Din};
         stb_d_r    <= stb_q_s;
         clk_d_r    <= clk_q_s;
      end
   end

   assign stb_q_s    = stb_sync_r[SYNC_STAGES-1];
   assign clk_q_s    = clk_sync_r[SYNC_STAGES-1];
   assign din_q_s    = din_sync_r[SYNC_STAGES-1];
   assign stb_rise_s = stb_q_s & ~stb_d_r;
   assign stb_fall_s = ~stb_q_s & stb_d_r;
   assign clk_rise_s = clk_q_s & ~clk_d_r;
   assign clk_fall_s = ~clk_q_s & clk_d_r;
   // A clock rise coinciding with the strobe rise still shifts, so the latch sees that bit.
   assign shift_en_s = clk_rise_s & (~stb_q_s | ~stb_d_r);

   // Next shift-register and saturating bit-count values for this sample.
   always_comb begin
      sr_nxt_s  = sr_r;
      cnt_nxt_s = cnt_r;
      if (stb_fall_s) begin
         cnt_nxt_s = 5'd0;
      end else begin
         cnt_nxt_s = cnt_r;
      end
      if (shift_en_s) begin
         sr_nxt_s = {sr_r[14:0], din_q_s};
         if (cnt_nxt_s != 5'd31) begin
            cnt_nxt_s = cnt_nxt_s + 5'd1;
         end else begin
            cnt_nxt_s = 5'd31;
         end
      end else begin
         sr_nxt_s = sr_r;
      end
   end

   assign word_ok_s   = stb_rise_s & cnt_nxt_s[4];
   assign frame_bad_s = stb_rise_s & ~cnt_nxt_s[4];
   assign wr_addr_s   = sr_nxt_s[11:8];
   assign wr_data_s   = sr_nxt_s[7:0];

   // Shift register, bit counter and chain output.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         sr_r   <= 16'h0000;
         cnt_r  <= 5'd0;
         dout_r <= 1'b0;
      end else begin
         sr_r  <= sr_nxt_s;
         cnt_r <= cnt_nxt_s;
         if (clk_fall_s) begin
            dout_r <= sr_r[15];
         end
      end
   end

   // Register file update, write/error pulses and saturating error counter.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         digit_r     <= '0;
         intensity_r <= 4'h0;
         scan_r      <= 3'd0;
         decode_r    <= 8'h00;
         shutdown_r  <= 1'b1;
`ifdef MAX7219_RX_DISPLAY_TEST_EN
         test_r      <= 1'b0;
`endif
         wr_stb_r    <= 1'b0;
         wr_addr_r   <= 4'h0;
         wr_data_r   <= 8'h00;
         frame_err_r <= 1'b0;
         err_cnt_r   <= '0;
      end else begin
         wr_stb_r    <= word_ok_s;
         frame_err_r <= frame_bad_s;
         if (word_ok_s) begin
            wr_addr_r <= wr_addr_s;
            wr_data_r <= wr_data_s;
            case (wr_addr_s)
               4'h1, 4'h2, 4'h3, 4'h4,
               4'h5, 4'h6, 4'h7, 4'h8: digit_r[wr_addr_s[2:0] - 3'd1] <= wr_data_s;
               4'h9: decode_r    <= wr_data_s;
               4'hA: intensity_r <= wr_data_s[3:0];
               4'hB: scan_r      <= wr_data_s[2:0];
               4'hC: shutdown_r  <= ~wr_data_s[0];
`ifdef MAX7219_RX_DISPLAY_TEST_EN
               4'hF: test_r      <= wr_data_s[0];
`endif
               default: begin
               end
            endcase
         end
         if (frame_bad_s && (err_cnt_r != {ERR_CNT_WIDTH{1'b1}})) begin
            err_cnt_r <= err_cnt_r + {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
         end
      end
   end

   // Displayed image: test lights everything, shutdown blanks, else rows up to the scan limit.
   always_comb begin
      frame_nxt_s = '0;
      for (int r = 0; r < 8; r++) begin
         for (int x = 0; x < 8; x++) begin
            if (test_s) begin
               frame_nxt_s[r][x] = 1'b1;
            end else if (shutdown_r) begin
               frame_nxt_s[r][x] = 1'b0;
            end else if (3'(r) <= scan_r) begin
               frame_nxt_s[r][x] = digit_r[r][7-x];
            end else begin
               frame_nxt_s[r][x] = 1'b0;
            end
         end
      end
   end

   // Image register, one cycle behind the register file.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         frame_r <= '0;
      end else begin
         frame_r <= frame_nxt_s;
      end
   end

   assign spi.SPI_Dout  = dout_r;
   assign o_FrameBuf    = frame_r;
   assign o_Intensity   = intensity_r;
   assign o_Scan_Limit  = scan_r;
   assign o_Decode      = decode_r;
   assign o_Shutdown    = shutdown_r;
   assign o_Test        = test_s;
   assign o_Wr_Stb      = wr_stb_r;
   assign o_Wr_Addr     = wr_addr_r;
   assign o_Wr_Data     = wr_data_r;
   assign o_Frame_Err   = frame_err_r;
   assign o_Err_Count   = err_cnt_r;

endmodule
